// File: rtl/alu_control_pkg.sv
// Shared constants for the ALU control slice: op codes, op classes, JR funct.
package alu_control_pkg;

    localparam int DATA_W_DEF = 16;

    // Decoded ALU operation codes
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;

    // Operation classes from the main decoder
    localparam logic [1:0] CLS_RTYPE  = 2'b00;
    localparam logic [1:0] CLS_BRANCH = 2'b01;
    localparam logic [1:0] CLS_SLTI   = 2'b10;
    localparam logic [1:0] CLS_MEM    = 2'b11;

    // R-type funct value selecting jump-register
    localparam logic [3:0] FUNCT_JR = 4'b1000;

    // Decoder output bundle
    typedef struct packed {
        logic [2:0] alu_ctrl;
        logic       jr_control;
    } dec_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: a, b, op code -> result and zero flag.
module alu_core
    import alu_control_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        alu_ctrl,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    // Unused codes fall through to ADD so every input yields a defined result
    always_comb begin
        result = a + b;
        case (alu_ctrl)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_SLT: result = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
            default: result = a + b;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_control.sv
// ALU control: decodes {alu_op,funct}, runs the ALU core and registers all
// four outputs together so they always describe the same input sample.
module alu_control
    import alu_control_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        alu_op,
    input  logic [3:0]        funct,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [2:0]        alu_ctrl,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              jr_control
);

    dec_t              dec;
    logic [DATA_W-1:0] core_result;
    logic              core_zero;

    // Operation decode; non-R-type classes ignore funct, unknown funct is ADD
    always_comb begin
        dec.alu_ctrl   = OP_ADD;
        dec.jr_control = 1'b0;
        case (alu_op)
            CLS_MEM:    dec.alu_ctrl = OP_ADD;
            CLS_SLTI:   dec.alu_ctrl = OP_SLT;
            CLS_BRANCH: dec.alu_ctrl = OP_SUB;
            default: begin
                case (funct)
                    4'b0000: dec.alu_ctrl = OP_ADD;
                    4'b0001: dec.alu_ctrl = OP_SUB;
                    4'b0010: dec.alu_ctrl = OP_AND;
                    4'b0011: dec.alu_ctrl = OP_OR;
                    4'b0100: dec.alu_ctrl = OP_SLT;
                    default: dec.alu_ctrl = OP_ADD;
                endcase
                dec.jr_control = (funct == FUNCT_JR);
            end
        endcase
    end

    alu_core #(.DATA_W(DATA_W)) u_core (
        .a        (a),
        .b        (b),
        .alu_ctrl (dec.alu_ctrl),
        .result   (core_result),
        .zero     (core_zero)
    );

    // Capture decode and datapath in one register stage; reset wins over data
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_ctrl   <= OP_ADD;
            result     <= '0;
            zero       <= 1'b1;
            jr_control <= 1'b0;
        end else begin
            alu_ctrl   <= dec.alu_ctrl;
            result     <= core_result;
            zero       <= core_zero;
            jr_control <= dec.jr_control;
        end
    end

endmodule

// File: tb/tb_alu_control.sv
// Bench for alu_control: directed vector table, back-to-back/reset sequence,
// and random vectors against an arithmetic reference model.
module tb_alu_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  alu_op;
    logic [3:0]  funct;
    logic [15:0] a, b;
    logic [2:0]  alu_ctrl;
    logic [15:0] result;
    logic        zero, jr_control;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [2:0]  ctrl;
        logic [15:0] res;
        logic        z;
        logic        jr;
    } exp_t;

    typedef struct {
        logic [1:0]  op;
        logic [3:0]  f;
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  ctrl;
        logic [15:0] res;
        logic        z;
        logic        jr;
    } vec_t;

    vec_t tbl[15];

    alu_control #(.DATA_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .alu_op     (alu_op),
        .funct      (funct),
        .a          (a),
        .b          (b),
        .alu_ctrl   (alu_ctrl),
        .result     (result),
        .zero       (zero),
        .jr_control (jr_control)
    );

    always #5 clk = ~clk;

    // Reference model computed straight from the decode/arithmetic rules
    function automatic exp_t model(input logic [1:0] op, input logic [3:0] f,
                                   input logic [15:0] x, input logic [15:0] y);
        exp_t m;
        int   ux, uy, sx, sy, r;
        logic [2:0] c;
        ux = int'(x);
        uy = int'(y);
        sx = (ux >= 32768) ? ux - 65536 : ux;
        sy = (uy >= 32768) ? uy - 65536 : uy;
        if (op == 2'd3)      c = 3'd0;
        else if (op == 2'd2) c = 3'd4;
        else if (op == 2'd1) c = 3'd1;
        else if (f <= 4'd4)  c = 3'(f);
        else                 c = 3'd0;
        case (c)
            3'd1:    r = (ux - uy + 65536) % 65536;
            3'd2:    r = int'(x & y);
            3'd3:    r = int'(x | y);
            3'd4:    r = (sx < sy) ? 1 : 0;
            default: r = (ux + uy) % 65536;
        endcase
        m.ctrl = c;
        m.res  = r[15:0];
        m.z    = (r == 0);
        m.jr   = (op == 2'd0) && (f == 4'd8);
        return m;
    endfunction

    function automatic exp_t reset_exp();
        exp_t m;
        m.ctrl = 3'd0; m.res = 16'h0000; m.z = 1'b1; m.jr = 1'b0;
        return m;
    endfunction

    task automatic check(input string name, input exp_t e);
        n_checks++;
        if (alu_ctrl === e.ctrl && result === e.res && zero === e.z && jr_control === e.jr)
            n_pass++;
        else
            $display("FAIL %s: got ctrl=%0d result=%h zero=%b jr=%b, expected ctrl=%0d result=%h zero=%b jr=%b",
                     name, alu_ctrl, result, zero, jr_control, e.ctrl, e.res, e.z, e.jr);
    endtask

    task automatic drive(input logic rst, input logic [1:0] op, input logic [3:0] f,
                         input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        reset = rst; alu_op = op; funct = f; a = x; b = y;
    endtask

    task automatic sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        exp_t tbl_e;
        logic [1:0]  r_op;
        logic [3:0]  r_f;
        logic [15:0] r_a, r_b;

        tbl[0]  = '{2'b00, 4'h0, 16'h00F0, 16'h0F0F, 3'd0, 16'h0FFF, 1'b0, 1'b0};
        tbl[1]  = '{2'b00, 4'h1, 16'h00F0, 16'h0F0F, 3'd1, 16'hF1E1, 1'b0, 1'b0};
        tbl[2]  = '{2'b00, 4'h2, 16'h00F0, 16'h0F0F, 3'd2, 16'h0000, 1'b1, 1'b0};
        tbl[3]  = '{2'b00, 4'h3, 16'h00F0, 16'h0F0F, 3'd3, 16'h0FFF, 1'b0, 1'b0};
        tbl[4]  = '{2'b00, 4'h4, 16'h00F0, 16'h0F0F, 3'd4, 16'h0001, 1'b0, 1'b0};
        tbl[5]  = '{2'b11, 4'h5, 16'hFFFF, 16'h0001, 3'd0, 16'h0000, 1'b1, 1'b0};
        tbl[6]  = '{2'b01, 4'h3, 16'h0005, 16'h0005, 3'd1, 16'h0000, 1'b1, 1'b0};
        tbl[7]  = '{2'b10, 4'h0, 16'hFFFF, 16'h0001, 3'd4, 16'h0001, 1'b0, 1'b0};
        tbl[8]  = '{2'b10, 4'h0, 16'h0001, 16'hFFFF, 3'd4, 16'h0000, 1'b1, 1'b0};
        tbl[9]  = '{2'b10, 4'h0, 16'h8000, 16'h8000, 3'd4, 16'h0000, 1'b1, 1'b0};
        tbl[10] = '{2'b00, 4'h8, 16'h1234, 16'h0001, 3'd0, 16'h1235, 1'b0, 1'b1};
        tbl[11] = '{2'b01, 4'h8, 16'h1234, 16'h0001, 3'd1, 16'h1233, 1'b0, 1'b0};
        tbl[12] = '{2'b00, 4'h7, 16'h0003, 16'h0004, 3'd0, 16'h0007, 1'b0, 1'b0};
        tbl[13] = '{2'b11, 4'h8, 16'h0002, 16'h0003, 3'd0, 16'h0005, 1'b0, 1'b0};
        tbl[14] = '{2'b00, 4'hF, 16'h0000, 16'h0000, 3'd0, 16'h0000, 1'b1, 1'b0};

        // Reset held for two edges with a live SUB on the inputs
        reset = 1'b1; alu_op = 2'b00; funct = 4'h1; a = 16'h1234; b = 16'h0001;
        sample();
        check("reset_edge1", reset_exp());
        sample();
        check("reset_edge2", reset_exp());

        // Directed vectors, one cycle latency each
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, tbl[i].op, tbl[i].f, tbl[i].a, tbl[i].b);
            sample();
            tbl_e.ctrl = tbl[i].ctrl; tbl_e.res = tbl[i].res;
            tbl_e.z = tbl[i].z; tbl_e.jr = tbl[i].jr;
            check($sformatf("vec%0d", i), tbl_e);
        end

        // Back-to-back for 8 cycles, reset asserted in cycle 5
        for (int c = 1; c <= 8; c++) begin
            r_op = 2'($urandom_range(0, 3));
            r_f  = 4'($urandom_range(0, 15));
            r_a  = 16'($urandom);
            r_b  = 16'($urandom);
            drive(c == 5, r_op, r_f, r_a, r_b);
            sample();
            e = (c == 5) ? reset_exp() : model(r_op, r_f, r_a, r_b);
            check($sformatf("b2b_cycle%0d", c), e);
        end

        // Random vectors against the model, biased toward corner operands
        for (int i = 0; i < 300; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_f  = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       begin r_a = 16'h8000; r_b = 16'($urandom_range(0, 3) == 0 ? 16'h8000 : 16'h7FFF); end
                1:       begin r_a = 16'($urandom); r_b = r_a; end
                default: begin r_a = 16'($urandom); r_b = 16'($urandom); end
            endcase
            drive(1'b0, r_op, r_f, r_a, r_b);
            sample();
            check($sformatf("rand%0d", i), model(r_op, r_f, r_a, r_b));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
